// File: rtl/pad_arbiter.sv
// Arbitrates one memory port between a core and a DMA engine. Core wins by
// default; DMA is forced in after STARVE_LIMIT consecutive core wins against it.
module pad_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // core side
  input  logic        core_read_i,
  input  logic        core_write_i,
  input  logic [31:0] core_address_i,
  input  logic [31:0] core_wdata_i,
  input  logic [1:0]  core_size_i,
  output logic        core_done_o,
  output logic [31:0] core_rdata_o,
  output logic        core_stall_o,
  // DMA side
  input  logic        dma_request_i,
  input  logic        dma_write_i,
  input  logic [31:0] dma_address_i,
  input  logic [31:0] dma_wdata_i,
  input  logic [1:0]  dma_size_i,
  output logic        dma_grant_o,
  output logic        dma_done_o,
  output logic [31:0] dma_rdata_o,
  // memory side
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_wdata_o,
  output logic [1:0]  mem_size_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    CORE_ACCESS,
    DMA_ACCESS
  } state_e;

  state_e        state_q;
  logic [CW-1:0] starve_q, starve_d;
  logic          mem_read_q, mem_write_q;
  logic [31:0]   mem_address_q, mem_wdata_q;
  logic [1:0]    mem_size_q;
  logic          core_done_q, dma_done_q, dma_grant_q;
  logic [31:0]   core_rdata_q, dma_rdata_q;

  logic core_req, core_wins, dma_wins;

  assign core_req  = core_read_i | core_write_i;
  assign core_wins = (state_q == IDLE) & core_req & ~(dma_request_i & (starve_q == LIMIT));
  assign dma_wins  = (state_q == IDLE) & dma_request_i & ~core_wins;

  // Counts core wins taken while DMA waits; any IDLE cycle without a DMA
  // request forgets the history.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (dma_wins || !dma_request_i) begin
        starve_d = '0;
      end else if (core_wins && (starve_q != LIMIT)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_size_q    <= '0;
      core_done_q   <= 1'b0;
      dma_done_q    <= 1'b0;
      dma_grant_q   <= 1'b0;
      core_rdata_q  <= '0;
      dma_rdata_q   <= '0;
    end else begin
      // NOTE: done flags default low each cycle so a completion is a single pulse.
      core_done_q <= 1'b0;
      dma_done_q  <= 1'b0;
      starve_q    <= starve_d;
      unique case (state_q)
        IDLE: begin
          if (core_wins) begin
            state_q       <= CORE_ACCESS;
            mem_read_q    <= core_read_i & ~core_write_i;
            mem_write_q   <= core_write_i;
            mem_address_q <= core_address_i;
            mem_wdata_q   <= core_wdata_i;
            mem_size_q    <= core_size_i;
          end else if (dma_wins) begin
            state_q       <= DMA_ACCESS;
            dma_grant_q   <= 1'b1;
            mem_read_q    <= ~dma_write_i;
            mem_write_q   <= dma_write_i;
            mem_address_q <= dma_address_i;
            mem_wdata_q   <= dma_wdata_i;
            mem_size_q    <= dma_size_i;
          end
        end
        CORE_ACCESS: begin
          if (mem_ready_i) begin
            if (mem_read_q) core_rdata_q <= mem_rdata_i;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            core_done_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        DMA_ACCESS: begin
          if (mem_ready_i) begin
            if (mem_read_q) dma_rdata_q <= mem_rdata_i;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            dma_done_q  <= 1'b1;
            dma_grant_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The stall drops in the completion cycle itself so the core can advance.
  assign core_stall_o  = core_req & ~((state_q == CORE_ACCESS) & mem_ready_i);

  assign core_done_o   = core_done_q;
  assign core_rdata_o  = core_rdata_q;
  assign dma_grant_o   = dma_grant_q;
  assign dma_done_o    = dma_done_q;
  assign dma_rdata_o   = dma_rdata_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_address_o = mem_address_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign mem_size_o    = mem_size_q;

endmodule

// File: tb/tb_pad_arbiter.sv
// Directed bench for pad_arbiter: per-cycle vector table plus hand-written
// sequences for asynchronous reset and DMA starvation.
module tb_pad_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_read, core_write;
  logic [31:0] core_address, core_wdata;
  logic [1:0]  core_size;
  logic        core_done, core_stall;
  logic [31:0] core_rdata;
  logic        dma_request, dma_write;
  logic [31:0] dma_address, dma_wdata;
  logic [1:0]  dma_size;
  logic        dma_grant, dma_done;
  logic [31:0] dma_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pad_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .core_read_i    (core_read),
    .core_write_i   (core_write),
    .core_address_i (core_address),
    .core_wdata_i   (core_wdata),
    .core_size_i    (core_size),
    .core_done_o    (core_done),
    .core_rdata_o   (core_rdata),
    .core_stall_o   (core_stall),
    .dma_request_i  (dma_request),
    .dma_write_i    (dma_write),
    .dma_address_i  (dma_address),
    .dma_wdata_i    (dma_wdata),
    .dma_size_i     (dma_size),
    .dma_grant_o    (dma_grant),
    .dma_done_o     (dma_done),
    .dma_rdata_o    (dma_rdata),
    .mem_read_o     (mem_read),
    .mem_write_o    (mem_write),
    .mem_address_o  (mem_address),
    .mem_wdata_o    (mem_wdata),
    .mem_size_o     (mem_size),
    .mem_ready_i    (mem_ready),
    .mem_rdata_i    (mem_rdata)
  );

  typedef struct {
    logic [1:0]  crw;     // {core_read, core_write}
    logic [31:0] caddr;
    logic [31:0] cwdata;
    logic [1:0]  csize;
    logic [1:0]  drw;     // {dma_request, dma_write}
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [1:0]  dsize;
    logic        rdy;
    logic [31:0] rdata;
    logic        stall;   // expected before the edge
    logic [1:0]  mrw;     // expected {mem_read, mem_write} after the edge
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [1:0]  msize;
    logic [2:0]  flags;   // expected {core_done, dma_done, dma_grant}
    logic [31:0] crdata;
    logic [31:0] drdata;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    core_read = 1'b0; core_write = 1'b0; core_address = '0; core_wdata = '0; core_size = '0;
    dma_request = 1'b0; dma_write = 1'b0; dma_address = '0; dma_wdata = '0; dma_size = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic apply(input int i, input vec_t v);
    @(negedge clk);
    {core_read, core_write} = v.crw;
    core_address = v.caddr; core_wdata = v.cwdata; core_size = v.csize;
    {dma_request, dma_write} = v.drw;
    dma_address = v.daddr; dma_wdata = v.dwdata; dma_size = v.dsize;
    mem_ready = v.rdy; mem_rdata = v.rdata;
    #1;
    check($sformatf("v%0d core_stall", i), 32'(core_stall), 32'(v.stall));
    @(posedge clk);
    #1;
    check($sformatf("v%0d mem_rw", i), 32'({mem_read, mem_write}), 32'(v.mrw));
    check($sformatf("v%0d mem_address", i), mem_address, v.maddr);
    check($sformatf("v%0d mem_wdata", i), mem_wdata, v.mwdata);
    check($sformatf("v%0d mem_size", i), 32'(mem_size), 32'(v.msize));
    check($sformatf("v%0d done_grant", i), 32'({core_done, dma_done, dma_grant}), 32'(v.flags));
    check($sformatf("v%0d core_rdata", i), core_rdata, v.crdata);
    check($sformatf("v%0d dma_rdata", i), dma_rdata, v.drdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic        own  [18];
    logic [31:0] addr [18];

    // core read 0x100, zero wait states
    vecs[0]  = '{2'b10, 32'h100, 32'h0, 2'd2, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,        1'b1, 2'b10, 32'h100, 32'h0, 2'd2, 3'b000, 32'h0, 32'h0};
    vecs[1]  = '{2'b10, 32'h100, 32'h0, 2'd2, 2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 32'hDEADBEEF, 1'b0, 2'b00, 32'h100, 32'h0, 2'd2, 3'b100, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,          1'b0, 2'b00, 32'h100, 32'h0, 2'd2, 3'b000, 32'hDEADBEEF, 32'h0};
    // core write, three wait states
    vecs[3]  = '{2'b01, 32'h200, 32'hCAFEF00D, 2'd1, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,        1'b1, 2'b01, 32'h200, 32'hCAFEF00D, 2'd1, 3'b000, 32'hDEADBEEF, 32'h0};
    vecs[4]  = '{2'b01, 32'h200, 32'hCAFEF00D, 2'd1, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h11111111, 1'b1, 2'b01, 32'h200, 32'hCAFEF00D, 2'd1, 3'b000, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{2'b01, 32'h200, 32'hCAFEF00D, 2'd1, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,        1'b1, 2'b01, 32'h200, 32'hCAFEF00D, 2'd1, 3'b000, 32'hDEADBEEF, 32'h0};
    vecs[6]  = '{2'b01, 32'h200, 32'hCAFEF00D, 2'd1, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,        1'b1, 2'b01, 32'h200, 32'hCAFEF00D, 2'd1, 3'b000, 32'hDEADBEEF, 32'h0};
    vecs[7]  = '{2'b01, 32'h200, 32'hCAFEF00D, 2'd1, 2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 32'h22222222, 1'b0, 2'b00, 32'h200, 32'hCAFEF00D, 2'd1, 3'b100, 32'hDEADBEEF, 32'h0};
    vecs[8]  = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,                1'b0, 2'b00, 32'h200, 32'hCAFEF00D, 2'd1, 3'b000, 32'hDEADBEEF, 32'h0};
    // read and write together execute as a write
    vecs[9]  = '{2'b11, 32'h300, 32'h12345678, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,        1'b1, 2'b01, 32'h300, 32'h12345678, 2'd0, 3'b000, 32'hDEADBEEF, 32'h0};
    vecs[10] = '{2'b11, 32'h300, 32'h12345678, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 32'h33333333, 1'b0, 2'b00, 32'h300, 32'h12345678, 2'd0, 3'b100, 32'hDEADBEEF, 32'h0};
    vecs[11] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,                1'b0, 2'b00, 32'h300, 32'h12345678, 2'd0, 3'b000, 32'hDEADBEEF, 32'h0};
    // DMA read
    vecs[12] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b10, 32'h400, 32'h0, 2'd2, 1'b0, 32'h0,        1'b0, 2'b10, 32'h400, 32'h0, 2'd2, 3'b001, 32'hDEADBEEF, 32'h0};
    vecs[13] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b10, 32'h400, 32'h0, 2'd2, 1'b1, 32'hA5A5A5A5, 1'b0, 2'b00, 32'h400, 32'h0, 2'd2, 3'b010, 32'hDEADBEEF, 32'hA5A5A5A5};
    vecs[14] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,          1'b0, 2'b00, 32'h400, 32'h0, 2'd2, 3'b000, 32'hDEADBEEF, 32'hA5A5A5A5};
    // DMA write with request dropped mid-access
    vecs[15] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b11, 32'h500, 32'h0BADF00D, 2'd1, 1'b0, 32'h0,        1'b0, 2'b01, 32'h500, 32'h0BADF00D, 2'd1, 3'b001, 32'hDEADBEEF, 32'hA5A5A5A5};
    vecs[16] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,                  1'b0, 2'b01, 32'h500, 32'h0BADF00D, 2'd1, 3'b001, 32'hDEADBEEF, 32'hA5A5A5A5};
    vecs[17] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 32'h44444444,          1'b0, 2'b00, 32'h500, 32'h0BADF00D, 2'd1, 3'b010, 32'hDEADBEEF, 32'hA5A5A5A5};
    vecs[18] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,                  1'b0, 2'b00, 32'h500, 32'h0BADF00D, 2'd1, 3'b000, 32'hDEADBEEF, 32'hA5A5A5A5};
    // core read with request dropped mid-access
    vecs[19] = '{2'b10, 32'h600, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,        1'b1, 2'b10, 32'h600, 32'h0, 2'd0, 3'b000, 32'hDEADBEEF, 32'hA5A5A5A5};
    vecs[20] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,          1'b0, 2'b10, 32'h600, 32'h0, 2'd0, 3'b000, 32'hDEADBEEF, 32'hA5A5A5A5};
    vecs[21] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 32'h5A5A5A5A, 1'b0, 2'b00, 32'h600, 32'h0, 2'd0, 3'b100, 32'h5A5A5A5A, 32'hA5A5A5A5};
    vecs[22] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,          1'b0, 2'b00, 32'h600, 32'h0, 2'd0, 3'b000, 32'h5A5A5A5A, 32'hA5A5A5A5};
    // simultaneous requests below the starvation limit: core first, then DMA
    vecs[23] = '{2'b10, 32'h700, 32'h0, 2'd2, 2'b10, 32'h800, 32'h0, 2'd2, 1'b0, 32'h0,        1'b1, 2'b10, 32'h700, 32'h0, 2'd2, 3'b000, 32'h5A5A5A5A, 32'hA5A5A5A5};
    vecs[24] = '{2'b10, 32'h700, 32'h0, 2'd2, 2'b10, 32'h800, 32'h0, 2'd2, 1'b1, 32'h66666666, 1'b0, 2'b00, 32'h700, 32'h0, 2'd2, 3'b100, 32'h66666666, 32'hA5A5A5A5};
    vecs[25] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b10, 32'h800, 32'h0, 2'd2, 1'b0, 32'h0,          1'b0, 2'b10, 32'h800, 32'h0, 2'd2, 3'b001, 32'h66666666, 32'hA5A5A5A5};
    vecs[26] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 32'h77777777, 1'b0, 2'b00, 32'h800, 32'h0, 2'd2, 3'b010, 32'h66666666, 32'h77777777};
    vecs[27] = '{2'b00, 32'h0, 32'h0, 2'd0, 2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,          1'b0, 2'b00, 32'h800, 32'h0, 2'd2, 3'b000, 32'h66666666, 32'h77777777};

    // reset state, with a core request pending that must not be granted
    idle_inputs();
    rst_n = 1'b0;
    core_read = 1'b1; core_address = 32'hF00; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset mem_rw", 32'({mem_read, mem_write}), 32'h0);
    check("reset mem_address", mem_address, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset mem_size", 32'(mem_size), 32'h0);
    check("reset done_grant", 32'({core_done, dma_done, dma_grant}), 32'h0);
    check("reset core_rdata", core_rdata, 32'h0);
    check("reset dma_rdata", dma_rdata, 32'h0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) apply(i, vecs[i]);

    // asynchronous reset in the middle of a core access
    @(negedge clk);
    idle_inputs();
    core_read = 1'b1; core_address = 32'h900;
    @(posedge clk);
    #1;
    check("rst_mid granted", 32'(mem_read), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid mem_read", 32'(mem_read), 32'h0);
    check("rst_mid mem_address", mem_address, 32'h0);
    check("rst_mid core_rdata", core_rdata, 32'h0);
    check("rst_mid dma_rdata", dma_rdata, 32'h0);
    @(negedge clk);
    core_read = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid no done", 32'(core_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid idle rw", 32'({mem_read, mem_write}), 32'h0);
    check("rst_mid idle done", 32'({core_done, dma_done, dma_grant}), 32'h0);

    // grant on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b0;
    core_read = 1'b1; core_address = 32'hA00; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("release held", 32'(mem_read), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release first grant", 32'(mem_read), 32'h1);
    check("release address", mem_address, 32'hA00);
    @(negedge clk);
    core_read = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release done", 32'(core_done), 32'h1);

    // starvation: both requesting continuously, zero wait states
    @(negedge clk);
    idle_inputs();
    core_read = 1'b1; core_address = 32'hB00;
    dma_request = 1'b1; dma_address = 32'hC00;
    mem_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 18; cyc++) begin
      @(posedge clk);
      #1;
      if (mem_read) begin
        own[n]  = dma_grant;
        addr[n] = mem_address;
        n++;
      end
    end
    check("starve access count", 32'(n), 32'd18);
    for (int i = 0; i < n; i++) begin
      check($sformatf("starve owner %0d", i), 32'(own[i]), (i % 9 == 8) ? 32'h1 : 32'h0);
      check($sformatf("starve address %0d", i), addr[i], (i % 9 == 8) ? 32'hC00 : 32'hB00);
    end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
